// File: rtl/ps2_scancode_rx_pkg.sv
// ps2_scancode_rx_pkg: shared prefix bytes, receiver states and game key codes
package ps2_scancode_rx_pkg;
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  typedef enum logic [3:0] {
    RX_IDLE   = 4'b0001,
    RX_DATA   = 4'b0010,
    RX_PARITY = 4'b0100,
    RX_STOP   = 4'b1000
  } rx_state_e;
  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_SPACE = 8'h29;
endpackage

// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if: PS/2 pins plus decoded scan-code event bus
// master: keyboard/pin side driving PS2Clk/PS2Data and consuming events
// slave:  receiver side sampling the pins and producing events
interface ps2_scancode_rx_if;
  logic       PS2Clk;
  logic       PS2Data;
  logic [7:0] ScanCode;
  logic       Extended;
  logic       Release;
  logic       CodeValid;
  logic       FrameErr;
  logic       Busy;
  modport master (output PS2Clk, PS2Data, input ScanCode, Extended, Release, CodeValid, FrameErr, Busy);
  modport slave (input PS2Clk, PS2Data, output ScanCode, Extended, Release, CodeValid, FrameErr, Busy);
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer, FILTER_LEN glitch filter, falling-edge pulse
// Ports: Clk, Reset (async, active-high); raw asynchronous line in;
// fall is a one-cycle pulse when the filtered level goes 1->0.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic s1_q, s2_q, level_q, level_d, fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (s2_q != level_q) ? cnt_q + 1'b1 : '0;
    level_d = level_q;
    fall_d = 1'b0;
    // the FILTER_LEN-th consecutive differing sample flips the level
    if (s2_q != level_q && cnt_q == CW'(FILTER_LEN - 1)) begin
      level_d = s2_q;
      cnt_d = '0;
      fall_d = level_q;
    end
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      level_q <= level_d;
      fall_q <= fall_d;
      cnt_q <= cnt_d;
    end
  end
  assign fall = fall_q;
endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard receiver folding E0/F0 prefixes into flags
// Ports: Clk, Reset (async, active-high); bus.slave takes PS2Clk/PS2Data and
// returns ScanCode/Extended/Release with CodeValid pulse, FrameErr pulse, Busy.
module ps2_scancode_rx
  import ps2_scancode_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic Clk,
  input logic Reset,
  ps2_scancode_rx_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic fall, good;
  logic data_s1_q, data_q;
  rx_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d, code_q, code_d;
  logic par_q, par_d, ext_q, ext_d, rel_q, rel_d;
  logic ext_out_q, ext_out_d, rel_out_q, rel_out_d, valid_q, valid_d, err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .Clk(Clk),
    .Reset(Reset),
    .raw(bus.PS2Clk),
    .fall(fall)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    byte_d = byte_q;
    par_d = par_q;
    ext_d = ext_q;
    rel_d = rel_q;
    code_d = code_q;
    ext_out_d = ext_out_q;
    rel_out_d = rel_out_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    tmo_d = (fall || state_q == RX_IDLE) ? '0 : tmo_q + 1'b1;
    // stop bit high and odd parity over data+parity
    good = data_q && ^{byte_q, par_q};
    if (fall) begin
      if (state_q == RX_IDLE) begin
        state_d = data_q ? RX_IDLE : RX_DATA;
        err_d = data_q;
        cnt_d = '0;
      end else if (state_q == RX_DATA) begin
        byte_d[cnt_q] = data_q;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == 3'd7) ? RX_PARITY : RX_DATA;
      end else if (state_q == RX_PARITY) begin
        par_d = data_q;
        state_d = RX_STOP;
      end else begin
        state_d = RX_IDLE;
        err_d = !good;
        if (good && byte_q == PS2_PREFIX_EXT) ext_d = 1'b1;
        else if (good && byte_q == PS2_PREFIX_BRK) rel_d = 1'b1;
        else if (good) begin
          code_d = byte_q;
          ext_out_d = ext_q;
          rel_out_d = rel_q;
          valid_d = 1'b1;
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
      end
    end else if (state_q != RX_IDLE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
      state_d = RX_IDLE;
      err_d = 1'b1;
    end
    // any discarded frame also drops pending prefixes
    if (err_d) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      data_s1_q <= 1'b1;
      data_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q <= '0;
      byte_q <= '0;
      par_q <= 1'b0;
      ext_q <= 1'b0;
      rel_q <= 1'b0;
      code_q <= '0;
      ext_out_q <= 1'b0;
      rel_out_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      data_s1_q <= bus.PS2Data;
      data_q <= data_s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      byte_q <= byte_d;
      par_q <= par_d;
      ext_q <= ext_d;
      rel_q <= rel_d;
      code_q <= code_d;
      ext_out_q <= ext_out_d;
      rel_out_q <= rel_out_d;
      valid_q <= valid_d;
      err_q <= err_d;
      tmo_q <= tmo_d;
    end
  end
  assign bus.ScanCode = code_q;
  assign bus.Extended = ext_out_q;
  assign bus.Release = rel_out_q;
  assign bus.CodeValid = valid_q;
  assign bus.FrameErr = err_q;
  assign bus.Busy = ~state_q[0];
endmodule
